// File: rtl/traffic_light_ctrl.sv
// Two-approach traffic-light sequencer with pedestrian shortening, flash mode and a seconds countdown on two 7-segment digits.
// Latency: lamps, AN, display and PHASE decode registered state; FLASH_EN acts on the next edge, PED_REQ on the edge it is sampled.
// Backpressure: none; every output is driven every cycle from free-running counters and the phase state.
module traffic_light_ctrl #(
   parameter int CLK_HZ      = 100000000,
   parameter int REFRESH_DIV = 250000,
   parameter int GREEN_S     = 20,
   parameter int YELLOW_S    = 5,
   parameter int ALLRED_S    = 3,
   parameter int PED_GREEN_S = 4
) (
   input  logic       CLK100MHZ,
   input  logic       RST,
   input  logic       PED_REQ,
   input  logic       FLASH_EN,
   output logic       NS_R,
   output logic       NS_Y,
   output logic       NS_G,
   output logic       EW_R,
   output logic       EW_Y,
   output logic       EW_G,
   output logic [7:0] AN,
   output logic [6:0] display,
   output logic [2:0] PHASE
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
   localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
   localparam logic [6:0] GREEN_L  = 7'(GREEN_S);
   localparam logic [6:0] YELLOW_L = 7'(YELLOW_S);
   localparam logic [6:0] ALLRED_L = 7'(ALLRED_S);
   localparam logic [6:0] PED_L    = 7'(PED_GREEN_S);
   localparam logic [6:0] SEG_DASH = 7'b1111110;

   typedef enum logic [2:0] {
      NS_GRN = 3'd0,
      NS_YEL = 3'd1,
      RED_A  = 3'd2,
      EW_GRN = 3'd3,
      EW_YEL = 3'd4,
      RED_B  = 3'd5,
      FLASH  = 3'd6
   } state_t;

   state_t        state, state_nxt, succ;
   logic [6:0]    remain, remain_nxt, succ_len;
   logic          ped_lat, ped_nxt;
   logic          flash_ph, flash_nxt;
   logic [PW-1:0] presc;
   logic [RW-1:0] refresh;
   logic          sel;
   logic          tick;
   logic          is_green;
   logic [6:0]    digit;

   assign tick     = (presc == PRESC_MAX);
   assign PHASE    = state;
   assign is_green = (state == NS_GRN) || (state == EW_GRN);

   // One-second prescaler, free-running from reset
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST)       presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PW'(1);
   end

   // Digit refresh counter; digit select flips each time it wraps
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         refresh <= '0;
         sel     <= 1'b0;
      end else if (refresh == REFRESH_MAX) begin
         refresh <= '0;
         sel     <= ~sel;
      end else begin
         refresh <= refresh + RW'(1);
      end
   end

   // Phase state register and its countdown, pedestrian latch and flash phase
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         state    <= RED_B;
         remain   <= ALLRED_L;
         ped_lat  <= 1'b0;
         flash_ph <= 1'b0;
      end else begin
         state    <= state_nxt;
         remain   <= remain_nxt;
         ped_lat  <= ped_nxt;
         flash_ph <= flash_nxt;
      end
   end

   // Fixed cycle order: successor of each normal phase and its duration
   always_comb begin
      succ     = RED_B;
      succ_len = ALLRED_L;
      case (state)
         NS_GRN:  begin succ = NS_YEL; succ_len = YELLOW_L; end
         NS_YEL:  begin succ = RED_A;  succ_len = ALLRED_L; end
         RED_A:   begin succ = EW_GRN; succ_len = GREEN_L;  end
         EW_GRN:  begin succ = EW_YEL; succ_len = YELLOW_L; end
         EW_YEL:  begin succ = RED_B;  succ_len = ALLRED_L; end
         RED_B:   begin succ = NS_GRN; succ_len = GREEN_L;  end
         default: ;
      endcase
   end

   // Next state: flash override first, then pedestrian shortening, then tick countdown
   always_comb begin
      state_nxt  = state;
      remain_nxt = remain;
      ped_nxt    = ped_lat | PED_REQ;
      flash_nxt  = flash_ph;
      if (FLASH_EN) begin
         state_nxt = FLASH;
         ped_nxt   = 1'b0;
         if (state == FLASH && tick) flash_nxt = ~flash_ph;
      end else if (state == FLASH) begin
         state_nxt  = RED_B;
         remain_nxt = ALLRED_L;
         flash_nxt  = 1'b0;
      end else if (PHASE == 3'd7) begin
         state_nxt  = RED_B;
         remain_nxt = ALLRED_L;
      end else if (is_green && ped_nxt && remain > PED_L) begin
         remain_nxt = PED_L;
      end else if (tick) begin
         if (remain == 7'd1) begin
            state_nxt  = succ;
            remain_nxt = succ_len;
            // A request is served by the green it shortened; yellow retires it
            if (succ == NS_YEL || succ == EW_YEL) ped_nxt = 1'b0;
         end else begin
            remain_nxt = remain - 7'd1;
         end
      end
   end

   // Lamp decode; anything unexpected shows all-red
   always_comb begin
      NS_R = 1'b0; NS_Y = 1'b0; NS_G = 1'b0;
      EW_R = 1'b0; EW_Y = 1'b0; EW_G = 1'b0;
      case (state)
         NS_GRN:  begin NS_G = 1'b1; EW_R = 1'b1; end
         NS_YEL:  begin NS_Y = 1'b1; EW_R = 1'b1; end
         EW_GRN:  begin EW_G = 1'b1; NS_R = 1'b1; end
         EW_YEL:  begin EW_Y = 1'b1; NS_R = 1'b1; end
         FLASH:   begin NS_Y = flash_ph; EW_Y = flash_ph; end
         default: begin NS_R = 1'b1; EW_R = 1'b1; end
      endcase
   end

   // Digit multiplex: ones on AN[0], tens on AN[1], dashes while flashing
   always_comb begin
      AN      = sel ? 8'hFD : 8'hFE;
      digit   = sel ? (remain / 7'd10) : (remain % 7'd10);
      display = SEG_DASH;
      if (state != FLASH) begin
         case (digit)
            7'd0:    display = 7'b0000001;
            7'd1:    display = 7'b1001111;
            7'd2:    display = 7'b0010010;
            7'd3:    display = 7'b0000110;
            7'd4:    display = 7'b1001100;
            7'd5:    display = 7'b0100100;
            7'd6:    display = 7'b0100000;
            7'd7:    display = 7'b0001111;
            7'd8:    display = 7'b0000000;
            7'd9:    display = 7'b0000100;
            default: display = SEG_DASH;
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl with small timing parameters.
// Expectations are queued per absolute cycle; a negedge monitor pops and compares.
// Cycle k counts active edges since reset release.
module tb_traffic_light_ctrl;

   logic       CLK100MHZ = 1'b0;
   logic       RST = 1'b1;
   logic       PED_REQ = 1'b0;
   logic       FLASH_EN = 1'b0;
   logic       NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G;
   logic [7:0] AN;
   logic [6:0] display;
   logic [2:0] PHASE;

   localparam int K_PH = 0, K_LAMP = 1, K_AN = 2, K_DISP = 3;
   localparam logic [7:0] S0 = 8'b0000_0001, S1 = 8'b0100_1111, S2 = 8'b0001_0010;
   localparam logic [7:0] S3 = 8'b0000_0110, S4 = 8'b0100_1100, S5 = 8'b0010_0100;
   localparam logic [7:0] SDASH = 8'b0111_1110;
   // lamp vectors {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G}
   localparam logic [7:0] L_ALLRED = 8'b00_100100, L_FLASH_ON = 8'b00_010010, L_DARK = 8'b0;

   traffic_light_ctrl #(
      .CLK_HZ(4), .REFRESH_DIV(2), .GREEN_S(5), .YELLOW_S(2), .ALLRED_S(1), .PED_GREEN_S(2)
   ) dut (
      .CLK100MHZ(CLK100MHZ), .RST(RST), .PED_REQ(PED_REQ), .FLASH_EN(FLASH_EN),
      .NS_R(NS_R), .NS_Y(NS_Y), .NS_G(NS_G), .EW_R(EW_R), .EW_Y(EW_Y), .EW_G(EW_G),
      .AN(AN), .display(display), .PHASE(PHASE)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] val;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   base = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge CLK100MHZ) cyc <= cyc + 1;

   function automatic logic [7:0] lamp_of(input int ph);
      case (ph)
         0:       return 8'b00_001100;
         1:       return 8'b00_010100;
         3:       return 8'b00_100001;
         4:       return 8'b00_100010;
         default: return L_ALLRED;
      endcase
   endfunction

   function automatic logic [7:0] rd(input int kind);
      case (kind)
         K_PH:    return {5'b0, PHASE};
         K_LAMP:  return {2'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G};
         K_AN:    return AN;
         default: return {1'b0, display};
      endcase
   endfunction

   task automatic push(input int k, input int kind, input logic [7:0] v, input string nm);
      exp_t e;
      e.cyc = base + k; e.kind = kind; e.val = v; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic to_k(input int k);
      while (cyc < base + k) begin
         @(posedge CLK100MHZ);
         #2;
      end
   endtask

   // Monitor: lamp safety every cycle, plus every queued expectation due now
   always @(negedge CLK100MHZ) begin
      if (!RST) begin
         checks++;
         if (NS_G && EW_G) begin
            errors++;
            $display("FAIL both_green cyc=%0d got NS_G=%b EW_G=%b want not both 1", cyc, NS_G, EW_G);
         end
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc <= cyc) begin
            checks++;
            if (q[i].cyc < cyc) begin
               errors++;
               $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", q[i].nm, q[i].cyc, cyc);
            end else if (rd(q[i].kind) !== q[i].val) begin
               errors++;
               $display("FAIL %s cyc=%0d got=%h want=%h", q[i].nm, cyc, rd(q[i].kind), q[i].val);
            end
            q.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int ph_tbl[8] = '{5, 0, 1, 2, 3, 4, 5, 0};
      int dw_tbl[8] = '{4, 20, 8, 4, 20, 8, 4, 4};
      int k;

      // Reset state while RST is held
      @(posedge CLK100MHZ); #2;
      push(cyc, K_PH,   8'd5,     "rst_phase");
      push(cyc, K_LAMP, L_ALLRED, "rst_lamps");
      push(cyc, K_AN,   8'hFE,    "rst_an");
      push(cyc, K_DISP, S1,       "rst_disp");
      @(posedge CLK100MHZ); #2;
      RST  = 1'b0;
      base = cyc;

      // Free run: phase and lamps every cycle through the second NS_GRN entry
      k = 0;
      for (int s = 0; s < 8; s++) begin
         for (int d = 0; d < dw_tbl[s]; d++) begin
            push(k, K_PH,   8'(ph_tbl[s]),   "run_phase");
            push(k, K_LAMP, lamp_of(ph_tbl[s]), "run_lamps");
            k++;
         end
      end

      // Countdown on the first NS_GRN
      push(4,  K_DISP, S5, "cd_ones5");
      push(8,  K_DISP, S4, "cd_ones4");
      push(12, K_DISP, S3, "cd_ones3");
      push(16, K_DISP, S2, "cd_ones2");
      push(20, K_DISP, S1, "cd_ones1");
      push(6,  K_DISP, S0, "cd_tens0");
      push(4,  K_AN, 8'hFE, "an_k4");
      push(5,  K_AN, 8'hFE, "an_k5");
      push(6,  K_AN, 8'hFD, "an_k6");
      push(7,  K_AN, 8'hFD, "an_k7");

      // Pedestrian in green: request at k=68 shortens remain to 2
      push(69, K_DISP, S2,   "pedg_remain2");
      push(72, K_DISP, S1,   "pedg_remain1");
      push(75, K_PH,   8'd0, "pedg_still_green");
      push(76, K_PH,   8'd1, "pedg_yellow_early");

      // Pedestrian in yellow: latched, acts on EW_GRN's second cycle
      push(83, K_PH,   8'd1, "pedy_yellow_full");
      push(84, K_PH,   8'd2, "pedy_red_a");
      push(88, K_PH,   8'd3, "pedy_ew_green");
      push(88, K_DISP, S5,   "pedy_enter5");
      push(89, K_DISP, S2,   "pedy_short2");
      push(95, K_PH,   8'd3, "pedy_green_end");
      push(96, K_PH,   8'd4, "pedy_ew_yellow");
      push(108, K_PH,  8'd0, "pedclr_ns_green");
      push(112, K_DISP, S4,  "pedclr_full_green");

      // Flash raised at k=145 (mid EW_GRN), released at k=155
      push(145, K_PH,   8'd3,       "fl_before");
      push(146, K_PH,   8'd6,       "fl_enter");
      push(146, K_LAMP, L_DARK,     "fl_dark0");
      push(148, K_LAMP, L_FLASH_ON, "fl_on");
      push(151, K_LAMP, L_FLASH_ON, "fl_on_hold");
      push(152, K_LAMP, L_DARK,     "fl_off");
      push(148, K_DISP, SDASH,      "fl_dash_ones");
      push(150, K_DISP, SDASH,      "fl_dash_tens");
      push(150, K_AN,   8'hFD,      "fl_an_tens");
      push(155, K_PH,   8'd6,       "fl_hold");
      push(156, K_PH,   8'd5,       "fl_exit_redb");
      push(156, K_LAMP, L_ALLRED,   "fl_exit_lamps");
      push(156, K_DISP, S1,         "fl_exit_remain1");
      push(160, K_PH,   8'd0,       "fl_then_green");

      // Reset asserted during NS_YEL at k=182
      push(181, K_PH,   8'd1,     "mid_pre_yellow");
      push(182, K_PH,   8'd5,     "mid_rst_phase");
      push(182, K_LAMP, L_ALLRED, "mid_rst_lamps");
      push(182, K_AN,   8'hFE,    "mid_rst_an");
      push(182, K_DISP, S1,       "mid_rst_disp");

      to_k(68);  PED_REQ = 1'b1;
      to_k(69);  PED_REQ = 1'b0;
      to_k(78);  PED_REQ = 1'b1;
      to_k(79);  PED_REQ = 1'b0;
      to_k(145); FLASH_EN = 1'b1;
      to_k(155); FLASH_EN = 1'b0;
      to_k(182); RST = 1'b1;
      @(posedge CLK100MHZ); #2;
      @(posedge CLK100MHZ); #2;
      RST  = 1'b0;
      base = cyc;

      push(0, K_PH,   8'd5, "post_rst_redb0");
      push(3, K_PH,   8'd5, "post_rst_redb3");
      push(4, K_PH,   8'd0, "post_rst_green");
      push(4, K_DISP, S5,   "post_rst_disp5");
      to_k(8);

      for (int i = 0; i < q.size(); i++) begin
         errors++;
         $display("FAIL %s never checked (due cyc=%0d)", q[i].nm, q[i].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
